// File: rtl/dispatch_1_4_if.sv
// Handshake bundle between upstream source, dispatcher and the downstream DEMUX_1_4 pair.
// Latency: none (wires only).
// Backpressure: IN_READY toward the source, CH_READY from the four demux channels.
interface dispatch_1_4_if #(
    parameter int BITS_NUM = 8
);
    logic [BITS_NUM-1:0] IN_DATA;
    logic                IN_VALID;
    logic                IN_READY;
    logic [3:0]          CH_READY;
    logic [BITS_NUM-1:0] X;
    logic [1:0]          SEL;
    logic                VALID;

    // Environment side: drives the input stream and channel readiness.
    modport master (
        output IN_DATA,
        output IN_VALID,
        input  IN_READY,
        output CH_READY,
        input  X,
        input  SEL,
        input  VALID
    );

    // Dispatcher side.
    modport slave (
        input  IN_DATA,
        input  IN_VALID,
        output IN_READY,
        input  CH_READY,
        output X,
        output SEL,
        output VALID
    );
endinterface

// File: rtl/dispatch_1_4.sv
// Round-robin 1-to-4 dispatcher: single holding register feeding DEMUX_1_4 X/SEL/VALID.
// Latency: word accepted at edge k is presented after edge k, earliest drain at edge k+1.
// Backpressure: IN_READY = EMPTY || drain; optional stall retarget under DISPATCH_1_4_RETARGET_EN.
module dispatch_1_4 #(
    parameter int BITS_NUM    = 8,
    parameter int STALL_LIMIT = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    dispatch_1_4_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q;
    logic [BITS_NUM-1:0] x_q;
    logic [1:0]          sel_q;
    logic [1:0]          ptr_q;

    logic full;
    logic drain;
    logic in_ready;
    logic accept;

    assign full     = (state_q == FULL);
    // The held word leaves only through the channel it currently targets.
    assign drain    = full && bus.CH_READY[sel_q];
    // Combinational on CH_READY so a drain and a new accept share one edge.
    assign in_ready = !full || drain;
    assign accept   = bus.IN_VALID && in_ready;

    assign bus.IN_READY = in_ready;
    assign bus.X        = x_q;
    assign bus.SEL      = sel_q;
    assign bus.VALID    = full;

`ifdef DISPATCH_1_4_RETARGET_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STALL_LIMIT);

    logic [SW-1:0] stall_q;
    logic          stalled;
    logic          alt_found;
    logic [1:0]    alt_sel;
    logic          retarget;

    assign stalled = full && !bus.CH_READY[sel_q];

    // First ready channel after the stuck one, searching SEL+1, SEL+2, SEL+3.
    always_comb begin
        alt_found = 1'b0;
        alt_sel   = sel_q;
        for (int k = 1; k < 4; k++) begin
            if (!alt_found && bus.CH_READY[sel_q + 2'(k)]) begin
                alt_found = 1'b1;
                alt_sel   = sel_q + 2'(k);
            end
        end
    end

    // A stalled word never drains, so retarget and drain are mutually exclusive.
    assign retarget = stalled && (stall_q == LIMIT) && alt_found;

    // Stall counter saturates at the limit and restarts whenever the word moves.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_q <= '0;
        end else if (drain || retarget) begin
            stall_q <= '0;
        end else if (stalled && (stall_q != LIMIT)) begin
            stall_q <= stall_q + 1'b1;
        end
    end
`else
    // Without retargeting the word waits on its channel forever; the limit is inert.
    localparam int unused_stall_limit = STALL_LIMIT;
    logic retarget;
    logic [1:0] alt_sel;
    assign retarget = 1'b0;
    assign alt_sel  = sel_q;
`endif

    // Holding register state machine; X/SEL keep their last values once drained.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= EMPTY;
            x_q     <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else if (accept) begin
            x_q     <= bus.IN_DATA;
            sel_q   <= ptr_q;
            ptr_q   <= ptr_q + 2'd1;
            state_q <= FULL;
        end else if (drain) begin
            state_q <= EMPTY;
        end else if (retarget) begin
            // Only the destination moves; the rotation pointer is left alone.
            sel_q   <= alt_sel;
        end
    end

endmodule

// File: tb/tb_dispatch_1_4.sv
// Directed bench for dispatch_1_4: rotation, backpressure, async reset and stall handling.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: exercised through CH_READY patterns; retarget branch follows DISPATCH_1_4_RETARGET_EN.
module tb_dispatch_1_4;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    dispatch_1_4_if #(.BITS_NUM(8)) bus ();

    dispatch_1_4 #(
        .BITS_NUM    (8),
        .STALL_LIMIT (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST_N        = 1'b0;
        bus.IN_DATA  = 8'h00;
        bus.IN_VALID = 1'b0;
        bus.CH_READY = 4'hF;

        // Reset state
        #1;
        chk("rst_valid", 32'(bus.VALID), 32'h0);
        chk("rst_x", 32'(bus.X), 32'h0);
        chk("rst_sel", 32'(bus.SEL), 32'h0);
        chk("rst_in_ready", 32'(bus.IN_READY), 32'h1);
        step();
        step();
        #2 RST_N = 1'b1;
        step();

        // Back-to-back stream with every channel ready
        for (int i = 0; i < 8; i++) begin
            bus.IN_DATA  = 8'(8'h10 + i);
            bus.IN_VALID = 1'b1;
            #1;
            chk("stream_in_ready", 32'(bus.IN_READY), 32'h1);
            step();
            chk("stream_sel", 32'(bus.SEL), 32'(i % 4));
            chk("stream_x", 32'(bus.X), 32'(8'h10 + i));
            chk("stream_valid", 32'(bus.VALID), 32'h1);
        end
        bus.IN_VALID = 1'b0;
        step();
        chk("stream_empty", 32'(bus.VALID), 32'h0);

        // Channel 1 blocked: A0 drains on 0, A1 holds on 1
        bus.CH_READY = 4'b1101;
        bus.IN_DATA  = 8'hA0;
        bus.IN_VALID = 1'b1;
        step();
        chk("bp_a0_sel", 32'(bus.SEL), 32'h0);
        chk("bp_a0_x", 32'(bus.X), 32'hA0);
        chk("bp_a0_in_ready", 32'(bus.IN_READY), 32'h1);
        bus.IN_DATA = 8'hA1;
        step();
        chk("bp_a1_sel", 32'(bus.SEL), 32'h1);
        chk("bp_a1_x", 32'(bus.X), 32'hA1);
        bus.IN_VALID = 1'b0;
        #1;
        chk("bp_a1_in_ready", 32'(bus.IN_READY), 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("bp_hold_valid", 32'(bus.VALID), 32'h1);
            chk("bp_hold_sel", 32'(bus.SEL), 32'h1);
            chk("bp_hold_in_ready", 32'(bus.IN_READY), 32'h0);
        end
        bus.CH_READY = 4'hF;
        #1;
        chk("bp_release_in_ready", 32'(bus.IN_READY), 32'h1);
        step();
        chk("bp_drained_valid", 32'(bus.VALID), 32'h0);
        chk("bp_drained_x", 32'(bus.X), 32'hA1);
        chk("bp_drained_sel", 32'(bus.SEL), 32'h1);

        // Async reset while holding 3C (pointer is at 2)
        bus.CH_READY = 4'h0;
        bus.IN_DATA  = 8'h3C;
        bus.IN_VALID = 1'b1;
        step();
        chk("ar_full_sel", 32'(bus.SEL), 32'h2);
        chk("ar_full_x", 32'(bus.X), 32'h3C);
        bus.IN_VALID = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.VALID), 32'h0);
        chk("ar_x", 32'(bus.X), 32'h0);
        chk("ar_sel", 32'(bus.SEL), 32'h0);
        #1;
        RST_N = 1'b1;
        bus.CH_READY = 4'hF;

        // Single word after reset lands on channel 0, then idles
        bus.IN_DATA  = 8'h55;
        bus.IN_VALID = 1'b1;
        step();
        chk("single_sel", 32'(bus.SEL), 32'h0);
        chk("single_valid", 32'(bus.VALID), 32'h1);
        bus.IN_VALID = 1'b0;
        step();
        chk("single_idle_valid", 32'(bus.VALID), 32'h0);
        chk("single_idle_x", 32'(bus.X), 32'h55);
        chk("single_idle_sel", 32'(bus.SEL), 32'h0);

        // Advance pointer so the next word targets channel 2
        bus.IN_DATA  = 8'h77;
        bus.IN_VALID = 1'b1;
        step();
        chk("st_77_sel", 32'(bus.SEL), 32'h1);
        bus.IN_DATA = 8'h88;
        step();
        chk("st_88_sel", 32'(bus.SEL), 32'h2);
        chk("st_88_x", 32'(bus.X), 32'h88);
        bus.IN_VALID = 1'b0;
        bus.CH_READY = 4'b1000;
        #1;
        chk("st_in_ready", 32'(bus.IN_READY), 32'h0);

`ifdef DISPATCH_1_4_RETARGET_EN
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rt_wait_sel", 32'(bus.SEL), 32'h2);
            chk("rt_wait_valid", 32'(bus.VALID), 32'h1);
        end
        step();
        chk("rt_sel", 32'(bus.SEL), 32'h3);
        chk("rt_x", 32'(bus.X), 32'h88);
        chk("rt_valid", 32'(bus.VALID), 32'h1);
        chk("rt_in_ready", 32'(bus.IN_READY), 32'h1);
        step();
        chk("rt_drained", 32'(bus.VALID), 32'h0);
        chk("rt_drained_sel", 32'(bus.SEL), 32'h3);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk("nort_sel", 32'(bus.SEL), 32'h2);
            chk("nort_valid", 32'(bus.VALID), 32'h1);
            chk("nort_in_ready", 32'(bus.IN_READY), 32'h0);
        end
        bus.CH_READY = 4'hF;
        step();
        chk("nort_drained", 32'(bus.VALID), 32'h0);
`endif

        // Pointer was untouched by any stall handling: next word goes to 3
        bus.CH_READY = 4'hF;
        bus.IN_DATA  = 8'h99;
        bus.IN_VALID = 1'b1;
        step();
        chk("ptr_sel", 32'(bus.SEL), 32'h3);
        chk("ptr_x", 32'(bus.X), 32'h99);
        bus.IN_VALID = 1'b0;
        step();
        chk("ptr_drained", 32'(bus.VALID), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
